uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised, oversampling UART receiver, the successor to the fixed 8-bit serial receiver. Synchronises the asynchronous serial line and detects the start bit with glitch rejection. Samples each bit at its midpoint, with configurable data width, parity and stop bits. Delivers each received word with parity/framing/overrun status over a valid/ready handshake to the downstream consumer (FIFO or register interface).

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 4..4095. HALF = CLKS_PER_BIT/2, integer division.
- DATA_BITS, 8: data bits per frame; legal range 5..9; transmitted LSB first.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_en  input  1  receiver enable; low = ignore the line / abort the current frame.
- rx_data  input  1  asynchronous serial line, idle high.
- rx_ready  input  1  consumer accepts the word when high while rx_valid is high.
- rx_word  output  DATA_BITS  received data word.
- rx_valid  output  1  rx_word and status flags are valid; held until accepted.
- parity_err  output  1  parity mismatch for the presented word; always 0 when PARITY=0.
- frame_err  output  1  a stop bit was sampled low for the presented word.
- overrun  output  1  sticky; a completed frame was dropped because rx_valid was still pending.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Input path: 2-flop synchroniser on rx_data, producing rxs. Both flops reset to 1. All FSM decisions use rxs only.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: if rx_en=1 and rxs=0 -> START, clear the bit counter and the clock counter.
- START: count HALF cycles, then sample rxs.
  - rxs=0 -> DATA.
  - rxs=1 -> glitch; return to IDLE with no output.
- DATA: every CLKS_PER_BIT cycles, sample rxs into bit position bit_cnt (LSB first).
  - After DATA_BITS samples -> PAR if PARITY != 0, else STOP.
- PAR: after CLKS_PER_BIT cycles, sample the parity bit.
  - Even: error if XOR(data, parity bit) = 1.
  - Odd: error if XOR(data, parity bit) = 0.
- STOP: sample each stop bit after CLKS_PER_BIT cycles. Any stop sample = 0 sets the frame error for this word.
  - After the last stop sample -> IDLE immediately, so the receiver resynchronises on the next falling edge mid stop bit.
- Completion, in the cycle after the last stop sample:
  - If rx_valid=0 or (rx_valid=1 and rx_ready=1): load rx_word, parity_err and frame_err, and set rx_valid=1.
  - Otherwise: drop the word, set overrun=1, and leave the presented word untouched.
- Handshake: rx_valid && rx_ready accepts the word; rx_valid falls the next cycle unless a new word loads in that same cycle. rx_word, parity_err and frame_err are stable while rx_valid=1.
- overrun clears on an accepting handshake, unless a new drop occurs in that same cycle.
- rx_en=0 in any non-IDLE state aborts to IDLE next cycle with no output. The output register and handshake are unaffected by rx_en.
- rst=1: FSM to IDLE and counters to 0. Outputs reset to: rx_word=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. Reset mid-frame discards the partial frame.

## Timing
- Counters: clock counter ceil(log2(CLKS_PER_BIT)) bits, wraps to 0 at each sample; bit counter 4 bits.
- Define T0 as the first clk edge at which rxs=0 is seen in IDLE.
- START sample at T0+HALF. Data bit k (0-based) sampled at T0+HALF+(k+1)*CLKS_PER_BIT.
- Frame bits after the start bit: N = DATA_BITS + (PARITY != 0) + STOP_BITS. Last sample at T0+HALF+N*CLKS_PER_BIT; rx_valid high one cycle later.
- Pin-to-valid latency adds 2 cycles for the synchroniser.
- busy rises the cycle after T0 and falls the cycle after the last stop sample.
- Back-to-back frames with no idle gap are received without loss, given the consumer keeps rx_ready high.

## Test plan
- 8N1, CLKS_PER_BIT=16, send 0xA5 -> rx_word=0xA5, rx_valid high exactly at T0+8+9*16+1, parity_err=0, frame_err=0.
- Glitch: rx_data low for 4 cycles in IDLE (CLKS_PER_BIT=16) -> FSM returns to IDLE at T0+8, no rx_valid, busy high for 8 cycles.
- 8E1, send 0x03 with parity bit 1 -> rx_word=0x03, parity_err=1. Same word with parity bit 0 -> parity_err=0. Repeat in 8O1 -> flags inverted.
- 8N2, second stop bit driven 0 -> rx_word correct, frame_err=1.
- Hold rx_ready=0 and send 0x11 then 0x22 -> rx_word stays 0x11 and overrun=1. Pulse rx_ready -> rx_valid=0 and overrun=0 next cycle.
- Assert rst during data bit 3 of a frame -> all outputs 0 next cycle, no word delivered. A following 0x5A frame is received correctly. Separately, drop rx_en mid-frame -> abort with no rx_valid.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling, word out one cycle after last stop sample.
// Output held on rx_valid until rx_ready; a frame finishing while a word is still pending is dropped and flags overrun.
module uart_rx_os #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx_data,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_word,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   sync1;
    logic                   rxs;
    logic [CW-1:0]          clk_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   fr_perr;
    logic                   fr_ferr;
    logic                   done;
    logic                   tick;
    logic                   last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_data;
            rxs   <= sync1;
        end
    end

    // START waits half a bit so every later sample lands mid-bit
    assign tick     = (clk_cnt == ((state == START) ? HALF_LAST : FULL_LAST));
    assign last_bit = (state == DATA) ? (bit_cnt == DATA_LAST) : (bit_cnt == STOP_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state != IDLE && !rx_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (rx_en && !rxs) state_nxt = START;
                START:   if (tick) state_nxt = rxs ? IDLE : DATA;
                DATA:    if (tick && last_bit) state_nxt = (PARITY != 0) ? PAR : STOP;
                PAR:     if (tick) state_nxt = STOP;
                STOP:    if (tick && last_bit) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            fr_perr <= 1'b0;
            fr_ferr <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                clk_cnt <= '0;
                bit_cnt <= '0;
                if (state_nxt == START) begin
                    fr_perr <= 1'b0;
                    fr_ferr <= 1'b0;
                end
            end else begin
                clk_cnt <= tick ? '0 : clk_cnt + CW'(1);
                if (tick) begin
                    case (state)
                        DATA: begin
                            shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                        end
                        PAR:  fr_perr <= (PARITY == 2) ? ~(^shreg ^ rxs) : (^shreg ^ rxs);
                        STOP: begin
                            if (!rxs) fr_ferr <= 1'b1;
                            bit_cnt <= bit_cnt + 4'd1;
                            done    <= last_bit && rx_en;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_word    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!rx_valid || rx_ready) begin
                rx_word    <= shreg;
                parity_err <= fr_perr;
                frame_err  <= fr_ferr;
                rx_valid   <= 1'b1;
                if (rx_valid) overrun <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: 8N1, 8E1, 8O1 and 8N2 receivers fed directed frames; a monitor scores accepted words.
module tb_uart_rx_os;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en;
    logic       rdy;
    logic [3:0] line;
    logic [7:0] word [4];
    logic       vld  [4];
    logic       pe   [4];
    logic       fe   [4];
    logic       ov   [4];
    logic       bsy  [4];

    int cmp = 0;
    int mis = 0;

    typedef struct {
        int         d;
        logic [7:0] w;
        logic       pe;
        logic       fe;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_data(line[0]), .rx_ready(rdy),
        .rx_word(word[0]), .rx_valid(vld[0]), .parity_err(pe[0]), .frame_err(fe[0]),
        .overrun(ov[0]), .busy(bsy[0]));
    uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_data(line[1]), .rx_ready(rdy),
        .rx_word(word[1]), .rx_valid(vld[1]), .parity_err(pe[1]), .frame_err(fe[1]),
        .overrun(ov[1]), .busy(bsy[1]));
    uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o1 (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_data(line[2]), .rx_ready(rdy),
        .rx_word(word[2]), .rx_valid(vld[2]), .parity_err(pe[2]), .frame_err(fe[2]),
        .overrun(ov[2]), .busy(bsy[2]));
    uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_data(line[3]), .rx_ready(rdy),
        .rx_word(word[3]), .rx_valid(vld[3]), .parity_err(pe[3]), .frame_err(fe[3]),
        .overrun(ov[3]), .busy(bsy[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        cmp++;
        if (act !== want) begin
            mis++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic expect_word(input int d, input logic [7:0] w, input logic p, input logic f);
        exp_t e;
        e.d = d; e.w = w; e.pe = p; e.fe = f;
        exp_q.push_back(e);
    endtask

    // bits[0] is the start bit; each bit is held CPB cycles, then the line idles high
    task automatic send(input int d, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            line[d] = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        line[d] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_word"},  32'(word[0]), 32'h0);
        chk({tag, "_valid"}, 32'(vld[0]),  32'h0);
        chk({tag, "_perr"},  32'(pe[0]),   32'h0);
        chk({tag, "_ferr"},  32'(fe[0]),   32'h0);
        chk({tag, "_ovr"},   32'(ov[0]),   32'h0);
        chk({tag, "_busy"},  32'(bsy[0]),  32'h0);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (vld[d] && rdy) begin
                cmp++;
                if (exp_q.size() == 0) begin
                    mis++;
                    $display("FAIL word%0d: got unexpected w=%0h, want no word", d, word[d]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.d != d || mon_e.w !== word[d] || mon_e.pe !== pe[d] || mon_e.fe !== fe[d]) begin
                        mis++;
                        $display("FAIL word%0d: got w=%0h pe=%0b fe=%0b, want dut%0d w=%0h pe=%0b fe=%0b",
                                 d, word[d], pe[d], fe[d], mon_e.d, mon_e.w, mon_e.pe, mon_e.fe);
                    end
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        rx_en = 1'b1;
        rdy   = 1'b1;
        line  = 4'hF;
        idle(3);
        chk_cleared("reset");
        rst = 1'b0;
        idle(4);

        // 8N1 0xA5: line falls after E0, T0 = E3, valid rises at E3+8+144+1 = E156
        expect_word(0, 8'hA5, 1'b0, 1'b0);
        fork
            send(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10);
            begin
                idle(2);   chk("a5_busy_pre",  32'(bsy[0]), 32'h0);
                idle(1);   chk("a5_busy_t0",   32'(bsy[0]), 32'h1);
                idle(152); chk("a5_valid_pre", 32'(vld[0]), 32'h0);
                idle(1);   chk("a5_valid_at",  32'(vld[0]), 32'h1);
            end
        join
        idle(20);

        // glitch: 4 low cycles, busy from E3 up to the half-bit sample at E11
        line[0] = 1'b0;
        idle(2); chk("gl_busy_pre", 32'(bsy[0]), 32'h0);
        idle(1); chk("gl_busy_t0",  32'(bsy[0]), 32'h1);
        idle(1); line[0] = 1'b1;
        idle(6); chk("gl_busy_last", 32'(bsy[0]), 32'h1);
        idle(1); chk("gl_busy_end",  32'(bsy[0]), 32'h0);
        idle(30); chk("gl_no_valid", 32'(vld[0]), 32'h0);

        // parity: 0x03 has even popcount, so even errs on pbit=1 and odd errs on pbit=0
        expect_word(1, 8'h03, 1'b1, 1'b0); send(1, {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        expect_word(1, 8'h03, 1'b0, 1'b0); send(1, {1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        expect_word(2, 8'h03, 1'b0, 1'b0); send(2, {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        expect_word(2, 8'h03, 1'b1, 1'b0); send(2, {1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        idle(20);

        // 8N2 with the second stop bit low, then a clean frame
        expect_word(3, 8'h3C, 1'b0, 1'b1); send(3, {1'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
        idle(40);
        expect_word(3, 8'hC5, 1'b0, 1'b0); send(3, {1'b0, 1'b1, 1'b1, 8'hC5, 1'b0}, 11);
        idle(20);

        // overrun: second word dropped while the first is held
        rdy = 1'b0;
        send(0, {2'b00, 1'b1, 8'h11, 1'b0}, 10);
        send(0, {2'b00, 1'b1, 8'h22, 1'b0}, 10);
        chk("ovr_word",  32'(word[0]), 32'h11);
        chk("ovr_valid", 32'(vld[0]),  32'h1);
        chk("ovr_flag",  32'(ov[0]),   32'h1);
        expect_word(0, 8'h11, 1'b0, 1'b0);
        rdy = 1'b1;
        idle(1);
        rdy = 1'b0;
        chk("ovr_valid_clr", 32'(vld[0]), 32'h0);
        chk("ovr_flag_clr",  32'(ov[0]),  32'h0);
        rdy = 1'b1;
        idle(20);

        // reset during data bit 3 of 0xF8; remaining bits are high so nothing restarts
        fork
            send(0, {2'b00, 1'b1, 8'hF8, 1'b0}, 10);
            begin
                idle(68);
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
                chk_cleared("midrst");
            end
        join
        idle(30);
        expect_word(0, 8'h5A, 1'b0, 1'b0); send(0, {2'b00, 1'b1, 8'h5A, 1'b0}, 10);
        idle(20);

        // rx_en dropped mid-frame: abort next cycle, held low until the line is idle again
        fork
            send(0, {2'b00, 1'b1, 8'h00, 1'b0}, 10);
            begin
                idle(50);
                rx_en = 1'b0;
                idle(1);
                chk("abort_busy", 32'(bsy[0]), 32'h0);
            end
        join
        rx_en = 1'b1;
        idle(30);
        chk("abort_no_valid", 32'(vld[0]), 32'h0);
        expect_word(0, 8'hC3, 1'b0, 1'b0); send(0, {2'b00, 1'b1, 8'hC3, 1'b0}, 10);
        idle(20);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
